// File: rtl/psum_accum_pool.sv
// Per-lane 2x2 partial-sum accumulator with signed max pooling.
// Accumulates acc_len beats per patch and emits linelen patches per configuration.
module psum_accum_pool #(
   parameter int X_MESH       = 16,
   parameter int COM_DATALEN  = 24,
   parameter int ACC_LEN_W    = 8,
   parameter int MAX_LINE_LEN = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              conf_input,
   input  logic [ACC_LEN_W-1:0]              acc_len,
   input  logic [MAX_LINE_LEN-1:0]           linelen,
   input  logic                              pooled,
   input  logic                              psum_valid,
   input  logic [4*COM_DATALEN*X_MESH-1:0]   psum_in,
   output logic [4*COM_DATALEN*X_MESH-1:0]   out_data_4,
   output logic [COM_DATALEN*X_MESH-1:0]     out_data_1,
   output logic                              dvalid,
   output logic                              busy,
   output logic                              done,
   output logic [2:0]                        dbg_state
);

   localparam int CW = COM_DATALEN;
   localparam int PW = 4*CW*X_MESH;
   localparam int OW = CW*X_MESH;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t                  state;
   logic [ACC_LEN_W-1:0]    acc_len_q;
   logic [ACC_LEN_W-1:0]    beat_cnt;
   logic [ACC_LEN_W-1:0]    last_beat;
   logic [MAX_LINE_LEN-1:0] linelen_q;
   logic [MAX_LINE_LEN-1:0] patch_cnt;
   logic                    pooled_q;
   logic [PW-1:0]           acc_q;
   logic [PW-1:0]           sum;
   logic [OW-1:0]           max_v;
   logic [CW-1:0]           m;

   // Debug view: latched pooled flag above the FSM state.
   assign dbg_state = {pooled_q, state};

   // acc_len of 0 behaves as 1, so the last beat index is 0 in both cases.
   assign last_beat = (acc_len_q == '0) ? '0 : acc_len_q - 1'b1;

   always_comb begin
      sum = '0;
      for (int l = 0; l < X_MESH; l++) begin
         for (int e = 0; e < 4; e++) begin
            if (beat_cnt == '0)
               sum[(l*4+e)*CW +: CW] = psum_in[(l*4+e)*CW +: CW];
            else
               sum[(l*4+e)*CW +: CW] = acc_q[(l*4+e)*CW +: CW] + psum_in[(l*4+e)*CW +: CW];
         end
      end
   end

   // Strict greater-than keeps the lower element index on ties.
   always_comb begin
      max_v = '0;
      m     = '0;
      for (int l = 0; l < X_MESH; l++) begin
         m = sum[(l*4)*CW +: CW];
         for (int e = 1; e < 4; e++) begin
            if ($signed(sum[(l*4+e)*CW +: CW]) > $signed(m))
               m = sum[(l*4+e)*CW +: CW];
         end
         max_v[l*CW +: CW] = m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         acc_len_q  <= '0;
         linelen_q  <= '0;
         pooled_q   <= 1'b0;
         beat_cnt   <= '0;
         patch_cnt  <= '0;
         acc_q      <= '0;
         out_data_4 <= '0;
         out_data_1 <= '0;
         dvalid     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         dvalid <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               beat_cnt  <= '0;
               patch_cnt <= '0;
               if (conf_input) begin
                  acc_len_q <= acc_len;
                  linelen_q <= linelen;
                  pooled_q  <= pooled;
                  if (linelen == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (psum_valid) begin
                  acc_q <= sum;
                  if (beat_cnt == last_beat) begin
                     out_data_4 <= sum;
                     out_data_1 <= max_v;
                     dvalid     <= 1'b1;
                     beat_cnt   <= '0;
                     patch_cnt  <= patch_cnt + 1'b1;
                     if (patch_cnt == linelen_q - 1'b1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_pool.sv
// Directed bench for psum_accum_pool: stimulus pushes expected patches,
// a negedge monitor pops and compares whenever dvalid is seen.
module tb_psum_accum_pool;

   localparam int X_MESH = 16;
   localparam int CW     = 24;
   localparam int PW     = 4*CW*X_MESH;
   localparam int OW     = CW*X_MESH;

   logic          clk;
   logic          rst_n;
   logic          conf_input;
   logic [7:0]    acc_len;
   logic [9:0]    linelen;
   logic          pooled;
   logic          psum_valid;
   logic [PW-1:0] psum_in;
   logic [PW-1:0] out_data_4;
   logic [OW-1:0] out_data_1;
   logic          dvalid;
   logic          busy;
   logic          done;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [PW-1:0] exp4_q[$];
   logic [OW-1:0] exp1_q[$];
   int            due_q[$];

   psum_accum_pool dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .conf_input (conf_input),
      .acc_len    (acc_len),
      .linelen    (linelen),
      .pooled     (pooled),
      .psum_valid (psum_valid),
      .psum_in    (psum_in),
      .out_data_4 (out_data_4),
      .out_data_1 (out_data_1),
      .dvalid     (dvalid),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Lane 0 carries {a,b,c,d}; the last lane carries the same values reversed.
   function automatic logic [PW-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [PW-1:0] v;
      int hi;
      v  = '0;
      hi = (X_MESH-1)*4;
      v[0*CW +: CW]      = CW'(a);
      v[1*CW +: CW]      = CW'(b);
      v[2*CW +: CW]      = CW'(c);
      v[3*CW +: CW]      = CW'(d);
      v[(hi+0)*CW +: CW] = CW'(d);
      v[(hi+1)*CW +: CW] = CW'(c);
      v[(hi+2)*CW +: CW] = CW'(b);
      v[(hi+3)*CW +: CW] = CW'(a);
      return v;
   endfunction

   function automatic logic [OW-1:0] pack1(input int mx);
      logic [OW-1:0] v;
      v = '0;
      v[0 +: CW]            = CW'(mx);
      v[(X_MESH-1)*CW +: CW] = CW'(mx);
      return v;
   endfunction

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int l = 0; l < X_MESH; l++) begin
            if (act[l*96 +: 96] !== exp[l*96 +: 96]) begin
               $display("FAIL %s chunk %0d actual=%h expected=%h", name, l, act[l*96 +: 96], exp[l*96 +: 96]);
               break;
            end
         end
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && dvalid) begin
         if (exp4_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dvalid actual=1 expected=0 at cycle %0d", cyc);
         end else begin
            logic [PW-1:0] e4;
            logic [OW-1:0] e1;
            int            due;
            e4  = exp4_q.pop_front();
            e1  = exp1_q.pop_front();
            due = due_q.pop_front();
            chk_int("dvalid_cycle", cyc, due);
            chk_vec("out_data_4", out_data_4, e4);
            chk_vec("out_data_1", PW'(out_data_1), PW'(e1));
         end
      end
   end

   // driver tasks; all driving happens 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input int al, input int ll, input logic pl);
      conf_input = 1'b1;
      acc_len    = 8'(al);
      linelen    = 10'(ll);
      pooled     = pl;
      tick();
      conf_input = 1'b0;
   endtask

   task automatic beat(input int a, input int b, input int c, input int d);
      psum_valid = 1'b1;
      psum_in    = pack4(a, b, c, d);
      tick();
      psum_valid = 1'b0;
   endtask

   task automatic beat_exp(input int a, input int b, input int c, input int d,
                           input int e0, input int e1, input int e2, input int e3, input int mx);
      psum_valid = 1'b1;
      psum_in    = pack4(a, b, c, d);
      exp4_q.push_back(pack4(e0, e1, e2, e3));
      exp1_q.push_back(pack1(mx));
      due_q.push_back(cyc + 1);
      tick();
      psum_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      conf_input = 1'b0;
      acc_len    = '0;
      linelen    = '0;
      pooled     = 1'b0;
      psum_valid = 1'b0;
      psum_in    = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // reset state
      chk_int("reset_dvalid", int'(dvalid), 0);
      chk_int("reset_busy", int'(busy), 0);
      chk_int("reset_done", int'(done), 0);
      chk_int("reset_state", int'(dbg_state), 0);
      chk_vec("reset_out4", out_data_4, '0);
      chk_vec("reset_out1", PW'(out_data_1), '0);

      // 1: three-beat accumulation
      configure(3, 1, 1'b1);
      chk_int("t1_busy", int'(busy), 1);
      chk_int("t1_state", int'(dbg_state), 3'b101);
      beat(1, 2, 3, 4);
      beat(1, 2, 3, 4);
      beat_exp(1, 2, 3, 4, 3, 6, 9, 12, 12);
      chk_int("t1_done", int'(done), 1);
      chk_int("t1_busy_low", int'(busy), 0);
      tick();
      chk_int("t1_done_pulse", int'(done), 0);
      chk_int("t1_idle", int'(dbg_state[1:0]), 0);

      // 2: back-to-back single-beat patches
      configure(1, 4, 1'b1);
      for (int k = 1; k <= 4; k++)
         beat_exp(k, 10+k, -k, 5, k, 10+k, -k, 5, 10+k);
      chk_int("t2_done", int'(done), 1);
      chk_int("t2_state_done", int'(dbg_state[1:0]), 2);
      tick();
      chk_int("t2_busy_after", int'(busy), 0);
      chk_int("t2_done_after", int'(done), 0);

      // 3: signed max and 24-bit wrap
      configure(1, 1, 1'b0);
      chk_int("t3_pooled0", int'(dbg_state), 3'b001);
      beat_exp(-5, -1, -7, -3, -5, -1, -7, -3, -1);
      tick();
      configure(2, 1, 1'b1);
      beat(32'h7FFFFF, 0, 0, 0);
      beat_exp(1, 0, 0, 0, 32'h800000, 0, 0, 0, 0);
      tick();

      // 4: acc_len 0 acts as 1; linelen 0 gives only a done pulse
      configure(0, 2, 1'b1);
      beat_exp(2, 3, 1, 0, 2, 3, 1, 0, 3);
      beat_exp(4, -2, 8, 1, 4, -2, 8, 1, 8);
      chk_int("t4_done", int'(done), 1);
      tick();
      configure(3, 0, 1'b1);
      chk_int("t4_ll0_done", int'(done), 1);
      chk_int("t4_ll0_busy", int'(busy), 0);
      tick();
      chk_int("t4_ll0_done_pulse", int'(done), 0);

      // 5: conf during run is ignored; psum in idle is dropped
      configure(2, 2, 1'b1);
      beat(1, 1, 1, 1);
      conf_input = 1'b1;
      acc_len    = 8'd5;
      linelen    = 10'd1;
      beat_exp(2, 2, 2, 2, 3, 3, 3, 3, 3);
      conf_input = 1'b0;
      chk_int("t5_still_busy", int'(busy), 1);
      beat(5, 0, 0, 0);
      beat_exp(1, 2, 0, 0, 6, 2, 0, 0, 6);
      chk_int("t5_done", int'(done), 1);
      tick();
      psum_valid = 1'b1;
      psum_in    = pack4(7, 7, 7, 7);
      tick();
      tick();
      tick();
      psum_valid = 1'b0;
      chk_int("t5_idle_busy", int'(busy), 0);
      chk_int("t5_idle_state", int'(dbg_state[1:0]), 0);

      // 6: async reset mid-run discards partial sums
      configure(3, 1, 1'b1);
      beat(9, 9, 9, 9);
      #1 rst_n = 1'b0;
      #1;
      chk_int("t6_rst_busy", int'(busy), 0);
      chk_int("t6_rst_state", int'(dbg_state), 0);
      chk_vec("t6_rst_out4", out_data_4, '0);
      chk_vec("t6_rst_out1", PW'(out_data_1), '0);
      tick();
      rst_n = 1'b1;
      tick();
      configure(3, 1, 1'b1);
      beat(1, 2, 3, 4);
      beat(10, 20, 30, 40);
      beat_exp(-1, -2, -3, -4, 10, 20, 30, 40, 40);
      tick();
      tick();
      tick();

      chk_int("scoreboard_drained", exp4_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
